// File: rtl/xbar_l2_bank_arb_pkg.sv
// Shared types and constants for the L2 crossbar bank arbiter.
// Contents:
//   CONFLICT_CNT_W - width of the optional conflict counter
//   MAX_IDX_W      - index width for the largest supported master count (16)
//   idx_width()    - master index width for a given master count (min 1)
//   rsp_entry_t    - response pipeline entry {valid, master idx, wen}
package xbar_l2_bank_arb_pkg;

    localparam int unsigned CONFLICT_CNT_W = 32;
    localparam int unsigned MAX_IDX_W      = 4;

    // Index width for n masters, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // idx is sized for the largest master count; users cast to their own width.
    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
        logic                 wen;
    } rsp_entry_t;

endpackage

// File: rtl/xbar_l2_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus winner index for a request vector.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   req       - per-master request vector
//   gnt       - one-hot grant (zero when no request)
//   gnt_idx   - index of the granted master
//   gnt_valid - a grant was issued this cycle
module xbar_l2_rr_arbiter
    import xbar_l2_bank_arb_pkg::*;
#(
    parameter  int unsigned N_MASTER = 9,
    localparam int unsigned IDX_W    = idx_width(N_MASTER)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_MASTER-1:0] req,
    output logic [N_MASTER-1:0] gnt,
    output logic [IDX_W-1:0]    gnt_idx,
    output logic                gnt_valid
);

    // Highest-priority master for the current cycle.
    logic [IDX_W-1:0] rr_ptr;

    // Two passes: masters at or above rr_ptr first, then the wrapped-around ones.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int m = 0; m < int'(N_MASTER); m++) begin
            if (!gnt_valid && req[m] && (IDX_W'(m) >= rr_ptr)) begin
                gnt_valid = 1'b1;
                gnt[m]    = 1'b1;
                gnt_idx   = IDX_W'(m);
            end
        end
        for (int m = 0; m < int'(N_MASTER); m++) begin
            if (!gnt_valid && req[m] && (IDX_W'(m) < rr_ptr)) begin
                gnt_valid = 1'b1;
                gnt[m]    = 1'b1;
                gnt_idx   = IDX_W'(m);
            end
        end
    end

    // Explicit wrap so non-power-of-two master counts return to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_valid) begin
            rr_ptr <= (gnt_idx == IDX_W'(N_MASTER - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/xbar_l2_bank_arb.sv
// N-master to single-bank request arbiter and latency-matched response router.
// Optional feature macro: XBAR_L2_BANK_ARB_CONFLICT_CNT_EN adds conflict_cnt_o.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   data_req_i ..     - per-master request, address, wen (1 = load), wdata, be
//   data_gnt_o        - combinational one-hot grant
//   data_r_valid_o    - response valid, BANK_LAT cycles after grant
//   data_r_rdata_o    - response data (bank data for loads, 0 for stores)
//   mem_*             - winner's request to the bank; mem_rdata_i read data
//   conflict_cnt_o    - cycles with two or more requesters (optional)
module xbar_l2_bank_arb
    import xbar_l2_bank_arb_pkg::*;
#(
    parameter int unsigned N_MASTER = 9,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BANK_LAT = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_MASTER-1:0]              data_req_i,
    input  logic [N_MASTER-1:0][ADDR_W-1:0]  data_add_i,
    input  logic [N_MASTER-1:0]              data_wen_i,
    input  logic [N_MASTER-1:0][DATA_W-1:0]  data_wdata_i,
    input  logic [N_MASTER-1:0][DATA_W/8-1:0] data_be_i,
    output logic [N_MASTER-1:0]              data_gnt_o,
    output logic [N_MASTER-1:0]              data_r_valid_o,
    output logic [N_MASTER-1:0][DATA_W-1:0]  data_r_rdata_o,
    output logic                             mem_req_o,
    output logic [ADDR_W-1:0]                mem_add_o,
    output logic                             mem_wen_o,
    output logic [DATA_W-1:0]                mem_wdata_o,
    output logic [DATA_W/8-1:0]              mem_be_o,
    input  logic [DATA_W-1:0]                mem_rdata_i
`ifdef XBAR_L2_BANK_ARB_CONFLICT_CNT_EN
    ,
    output logic [CONFLICT_CNT_W-1:0]        conflict_cnt_o
`endif
);

    localparam int unsigned IDX_W = idx_width(N_MASTER);

    logic [N_MASTER-1:0] req_eff;
    logic [N_MASTER-1:0] gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_valid;
    rsp_entry_t          pipe [BANK_LAT];
    rsp_entry_t          rsp_last;

    // Requests are masked while in reset so no grant or bank access escapes.
    assign req_eff = rst ? '0 : data_req_i;

    xbar_l2_rr_arbiter #(.N_MASTER(N_MASTER)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_eff),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign data_gnt_o = gnt;
    assign mem_req_o  = gnt_valid;

    // Winner's fields to the bank; all zero with no grant.
    always_comb begin
        mem_add_o   = '0;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        for (int m = 0; m < int'(N_MASTER); m++) begin
            if (gnt[m]) begin
                mem_add_o   = data_add_i[m];
                mem_wen_o   = data_wen_i[m];
                mem_wdata_o = data_wdata_i[m];
                mem_be_o    = data_be_i[m];
            end
        end
    end

    // Response pipeline matching the bank read latency; reset drops in-flight entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < int'(BANK_LAT); s++) begin
                pipe[s] <= '0;
            end
        end else begin
            pipe[0].valid <= gnt_valid;
            pipe[0].idx   <= MAX_IDX_W'(gnt_idx);
            pipe[0].wen   <= mem_wen_o;
            for (int s = 1; s < int'(BANK_LAT); s++) begin
                pipe[s] <= pipe[s-1];
            end
        end
    end

    assign rsp_last = pipe[BANK_LAT-1];

    // Route the retiring response to its master; stores return zero data.
    always_comb begin
        data_r_valid_o = '0;
        data_r_rdata_o = '0;
        for (int m = 0; m < int'(N_MASTER); m++) begin
            if (!rst && rsp_last.valid && (rsp_last.idx == MAX_IDX_W'(m))) begin
                data_r_valid_o[m] = 1'b1;
                data_r_rdata_o[m] = rsp_last.wen ? mem_rdata_i : '0;
            end
        end
    end

`ifdef XBAR_L2_BANK_ARB_CONFLICT_CNT_EN
    logic multi_req;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign multi_req = (req_eff & (req_eff - N_MASTER'(1))) != '0;

    // Saturating count of contended cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_o <= '0;
        end else if (multi_req && (conflict_cnt_o != '1)) begin
            conflict_cnt_o <= conflict_cnt_o + CONFLICT_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_xbar_l2_bank_arb.sv
// Self-checking bench for xbar_l2_bank_arb with a queue-based reference model.
module tb_xbar_l2_bank_arb;

    localparam int unsigned N   = 9;
    localparam int unsigned AW  = 14;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned LAT = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req;
    logic [N-1:0][AW-1:0]  add;
    logic [N-1:0]          wen;
    logic [N-1:0][DW-1:0]  wdata;
    logic [N-1:0][BW-1:0]  be;
    logic [N-1:0]          gnt;
    logic [N-1:0]          rvalid;
    logic [N-1:0][DW-1:0]  rdata;
    logic                  mem_req;
    logic [AW-1:0]         mem_add;
    logic                  mem_wen;
    logic [DW-1:0]         mem_wdata;
    logic [BW-1:0]         mem_be;
    logic [DW-1:0]         mem_rdata;
`ifdef XBAR_L2_BANK_ARB_CONFLICT_CNT_EN
    logic [31:0]           conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xbar_l2_bank_arb #(.N_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .BANK_LAT(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_req_i     (req),
        .data_add_i     (add),
        .data_wen_i     (wen),
        .data_wdata_i   (wdata),
        .data_be_i      (be),
        .data_gnt_o     (gnt),
        .data_r_valid_o (rvalid),
        .data_r_rdata_o (rdata),
        .mem_req_o      (mem_req),
        .mem_add_o      (mem_add),
        .mem_wen_o      (mem_wen),
        .mem_wdata_o    (mem_wdata),
        .mem_be_o       (mem_be),
        .mem_rdata_i    (mem_rdata)
`ifdef XBAR_L2_BANK_ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    // Reference model: priority pointer, cycle count and outstanding responses by due cycle.
    typedef struct {
        int due;
        int idx;
        bit is_load;
    } pend_t;

    pend_t pq[$];
    int    ptr;
    int    cyc;
    logic [31:0] cnt_m;

    logic [N-1:0]          exp_gnt;
    logic [N-1:0]          exp_rvalid;
    logic [N-1:0][DW-1:0]  exp_rdata;
    logic [1+AW+1+DW+BW-1:0] exp_mem;
    int                    exp_win;

    function automatic int popcnt(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < int'(N); i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_eval();
        exp_gnt    = '0;
        exp_rvalid = '0;
        exp_rdata  = '0;
        exp_mem    = '0;
        exp_win    = -1;
        if (!rst) begin
            for (int k = 0; k < int'(N); k++) begin
                int m;
                m = (ptr + k) % int'(N);
                if (exp_win < 0 && req[m]) exp_win = m;
            end
            if (exp_win >= 0) begin
                exp_gnt[exp_win] = 1'b1;
                exp_mem = {1'b1, add[exp_win], wen[exp_win], wdata[exp_win], be[exp_win]};
            end
            foreach (pq[i]) begin
                if (pq[i].due == cyc) begin
                    exp_rvalid[pq[i].idx] = 1'b1;
                    exp_rdata[pq[i].idx]  = pq[i].is_load ? mem_rdata : '0;
                end
            end
        end
    endtask

    // One clock cycle: evaluate, clock, commit the model, return at the falling edge.
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (!rst) begin
            if (exp_win >= 0) begin
                pq.push_back('{due: cyc + int'(LAT), idx: exp_win, is_load: bit'(wen[exp_win])});
                ptr = (exp_win + 1) % int'(N);
            end
            if (popcnt(req) >= 2 && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
        end
        cyc++;
        while (pq.size() > 0 && pq[0].due < cyc) void'(pq.pop_front());
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req   = '0;
        add   = '0;
        wen   = '0;
        wdata = '0;
        be    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        pq.delete();
        ptr   = 0;
        cnt_m = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cyc       = 0;
        mem_rdata = 32'hA5A5_5A5A;
        clear_inputs();
        pq.delete();
        ptr   = 0;
        cnt_m = '0;
        @(negedge clk);
        req = N'($urandom) | N'(1);
        wen = '1;
        #1;
        checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%h exp=0", gnt); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        checks++; if (rvalid !== '0) begin failures++; $display("FAIL reset_rvalid got=%h exp=0", rvalid); end
        checks++; if (rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
`ifdef XBAR_L2_BANK_ARB_CONFLICT_CNT_EN
        checks++; if (conflict_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt); end
`endif
        do_reset();
    endtask

    task automatic test_single_load();
        logic [N-1:0] oh3;
        oh3 = N'(1) << 3;
        do_reset();
        mem_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c <= int'(LAT) + 1; c++) begin
            clear_inputs();
            if (c == 0) begin
                req[3] = 1'b1;
                wen[3] = 1'b1;
                add[3] = AW'(14'h0123);
            end
            #1;
            if (c == 0) begin
                checks++; if (gnt !== oh3) begin failures++; $display("FAIL load_gnt got=%h exp=%h", gnt, oh3); end
                checks++; if ({mem_req, mem_add, mem_wen} !== {1'b1, AW'(14'h0123), 1'b1})
                    begin failures++; $display("FAIL load_mem got=%b/%h/%b exp=1/0123/1", mem_req, mem_add, mem_wen); end
            end
            checks++; if (rvalid !== ((c == int'(LAT)) ? oh3 : N'(0)))
                begin failures++; $display("FAIL load_rvalid c=%0d got=%h", c, rvalid); end
            if (c == int'(LAT)) begin
                checks++; if (rdata[3] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", rdata[3]); end
            end
            tick();
        end
    endtask

    task automatic test_rr_order();
        int ord[3] = '{0, 4, 8};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req = '0;
            req[0] = 1'b1;
            req[4] = 1'b1;
            req[8] = 1'b1;
            #1;
            checks++; if (gnt !== (N'(1) << ord[i % 3]))
                begin failures++; $display("FAIL rr_order i=%0d got=%h exp=%h", i, gnt, N'(1) << ord[i % 3]); end
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = '0;
        req[8] = 1'b1;
        #1;
        checks++; if (gnt !== (N'(1) << 8)) begin failures++; $display("FAIL wrap_first got=%h exp=%h", gnt, N'(1) << 8); end
        tick();
        req[0] = 1'b1;
        #1;
        checks++; if (gnt !== N'(1)) begin failures++; $display("FAIL wrap_to_0 got=%h exp=001", gnt); end
        tick();
    endtask

    task automatic test_back_to_back_store();
        logic [N-1:0] oh2;
        oh2 = N'(1) << 2;
        do_reset();
        for (int c = 0; c < int'(LAT) + 6; c++) begin
            clear_inputs();
            mem_rdata = $urandom | 32'h1;
            if (c < 4) begin
                req[2]   = 1'b1;
                wdata[2] = $urandom;
                be[2]    = BW'($urandom);
            end
            #1;
            if (c < 4) begin
                checks++; if (gnt !== oh2 || mem_wdata !== wdata[2] || mem_wen !== 1'b0)
                    begin failures++; $display("FAIL store_req c=%0d got=%h/%h exp=%h/%h", c, gnt, mem_wdata, oh2, wdata[2]); end
            end
            checks++; if (rvalid !== ((c >= int'(LAT) && c < int'(LAT) + 4) ? oh2 : N'(0)))
                begin failures++; $display("FAIL store_rvalid c=%0d got=%h", c, rvalid); end
            checks++; if (rdata !== '0) begin failures++; $display("FAIL store_rdata c=%0d got=%h exp=0", c, rdata); end
            tick();
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        req[1] = 1'b1;
        wen[1] = 1'b1;
        #1;
        checks++; if (gnt !== (N'(1) << 1)) begin failures++; $display("FAIL midrst_gnt got=%h exp=002", gnt); end
        tick();
        clear_inputs();
        rst = 1'b1;
        pq.delete();
        ptr   = 0;
        cnt_m = '0;
        #1;
        checks++; if (rvalid !== '0) begin failures++; $display("FAIL midrst_rvalid_in_rst got=%h exp=0", rvalid); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < int'(LAT) + 2; c++) begin
            #1;
            checks++; if (rvalid !== '0) begin failures++; $display("FAIL midrst_rvalid c=%0d got=%h exp=0", c, rvalid); end
            tick();
        end
        req[0] = 1'b1;
        req[5] = 1'b1;
        #1;
        checks++; if (gnt !== N'(1)) begin failures++; $display("FAIL midrst_prio got=%h exp=001", gnt); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = (c % 5 == 0) ? N'(0) : (N'($urandom) & ((c % 3 == 0) ? N'($urandom) : '1));
            for (int m = 0; m < int'(N); m++) begin
                add[m]   = AW'($urandom);
                wen[m]   = 1'($urandom);
                wdata[m] = $urandom;
                be[m]    = BW'($urandom);
            end
            mem_rdata = $urandom;
            #1;
            model_eval();
            checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL rand_gnt c=%0d got=%h exp=%h", c, gnt, exp_gnt); end
            checks++; if ({mem_req, mem_add, mem_wen, mem_wdata, mem_be} !== exp_mem)
                begin failures++; $display("FAIL rand_mem c=%0d got=%h exp=%h", c, {mem_req, mem_add, mem_wen, mem_wdata, mem_be}, exp_mem); end
            checks++; if (rvalid !== exp_rvalid) begin failures++; $display("FAIL rand_rvalid c=%0d got=%h exp=%h", c, rvalid, exp_rvalid); end
            checks++; if (rdata !== exp_rdata) begin failures++; $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, rdata, exp_rdata); end
`ifdef XBAR_L2_BANK_ARB_CONFLICT_CNT_EN
            checks++; if (conflict_cnt !== cnt_m) begin failures++; $display("FAIL rand_cnt c=%0d got=%0d exp=%0d", c, conflict_cnt, cnt_m); end
`endif
            tick();
        end
    endtask

`ifdef XBAR_L2_BANK_ARB_CONFLICT_CNT_EN
    task automatic test_conflict_cnt();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            int a, b;
            clear_inputs();
            a = $urandom_range(0, N - 1);
            b = (a + 1 + $urandom_range(0, N - 2)) % int'(N);
            req[a] = 1'b1;
            if (c < 5) req[b] = 1'b1;
            tick();
        end
        clear_inputs();
        #1;
        checks++; if (conflict_cnt !== 32'd5) begin failures++; $display("FAIL conflict_cnt got=%0d exp=5", conflict_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_load();
        test_rr_order();
        test_wrap();
        test_back_to_back_store();
        test_reset_midop();
        test_random();
`ifdef XBAR_L2_BANK_ARB_CONFLICT_CNT_EN
        test_conflict_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
